// File: rtl/conv_pkg.sv
// Shared types and helpers for the saturating streaming convolution engine.
// saturate() works on 64-bit values, so result widths up to 32 bits are supported.
package conv_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD_F,
    S_LOAD_X,
    S_MAC,
    S_OUT
  } conv_state_t;

  // Clamp v to the signed range of a w-bit value; the caller narrows the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/conv_stream_sat_if.sv
// Coefficient, sample and result streams of conv_stream_sat, each a valid/ready pair.
interface conv_stream_sat_if #(parameter int WIDTH = 32);
  logic signed [WIDTH-1:0] s_data_in_f;
  logic                    s_valid_f;
  logic                    s_ready_f;
  logic signed [WIDTH-1:0] s_data_in_x;
  logic                    s_valid_x;
  logic                    s_ready_x;
  logic signed [WIDTH-1:0] m_data_out_y;
  logic                    m_valid_y;
  logic                    m_ready_y;

  modport slave (
    input  s_data_in_f, s_valid_f, s_data_in_x, s_valid_x, m_ready_y,
    output s_ready_f, s_ready_x, m_data_out_y, m_valid_y
  );

  modport master (
    output s_data_in_f, s_valid_f, s_data_in_x, s_valid_x, m_ready_y,
    input  s_ready_f, s_ready_x, m_data_out_y, m_valid_y
  );
endinterface

// File: rtl/conv_mem.sv
// Single-port synchronous RAM with one-cycle registered read; contents are never reset.
module conv_mem #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 43,
  parameter int LOGSIZE = 6
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [LOGSIZE-1:0]      i_addr,
  input  logic signed [WIDTH-1:0] i_wdata,
  output logic signed [WIDTH-1:0] o_rdata
);
  logic signed [WIDTH-1:0] r_mem [SIZE];
  logic signed [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/conv_stream_sat.sv
// Streaming valid-convolution y[k] = sum x[k+j]*f[j] with per-step saturation.
// Define CONV_RELU_EN to zero every non-positive final result.
//   state    | meaning
//   S_WAIT   | idle; filter load has priority over a sample vector
//   S_LOAD_F | accept LENF coefficients
//   S_LOAD_X | accept LENX samples
//   S_MAC    | issue LENF reads, accumulate through the read pipeline
//   S_OUT    | hold y[k] until the downstream handshake
module conv_stream_sat
  import conv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LENX  = 43,
  parameter int LENF  = 16
) (
  input  logic             clk,
  input  logic             reset,
  conv_stream_sat_if.slave bus
);
  localparam int LENY  = LENX - LENF + 1;
  localparam int ADDRX = $clog2(LENX);
  localparam int ADDRF = $clog2(LENF);
  localparam logic [ADDRF-1:0] F_LAST = ADDRF'(LENF - 1);
  localparam logic [ADDRX-1:0] X_LAST = ADDRX'(LENX - 1);
  localparam logic [ADDRX-1:0] Y_LAST = ADDRX'(LENY - 1);

  conv_state_t r_state, w_next;
  logic [ADDRF-1:0] r_wa_f, r_j, w_addr_f;
  logic [ADDRX-1:0] r_wa_x, r_k, w_addr_x;
  logic r_loaded, r_issue_done, r_rd_vld, r_rd_last, r_done;
  logic w_rdy_f, w_rdy_x, w_vld_y, w_hs_f, w_hs_x, w_hs_y, w_issue;
  logic signed [WIDTH-1:0] r_acc, r_y, w_rd_x, w_rd_f, w_psat, w_acc_next, w_y_final;
  logic signed [2*WIDTH-1:0] w_xe, w_fe, w_prod;
  logic signed [WIDTH:0] w_sum;

  assign w_hs_f  = bus.s_valid_f & w_rdy_f;
  assign w_hs_x  = bus.s_valid_x & w_rdy_x;
  assign w_hs_y  = bus.m_ready_y & w_vld_y;
  assign w_issue = (r_state == S_MAC) & ~r_issue_done;

  // The single port is shared: write counter while loading, k+j / j while computing.
  assign w_addr_x = (r_state == S_MAC) ? (r_k + ADDRX'(r_j)) : r_wa_x;
  assign w_addr_f = (r_state == S_MAC) ? r_j : r_wa_f;

  conv_mem #(.WIDTH(WIDTH), .SIZE(LENX), .LOGSIZE(ADDRX)) u_mem_x (
    .clk(clk), .i_we(w_hs_x), .i_re(w_issue), .i_addr(w_addr_x),
    .i_wdata(bus.s_data_in_x), .o_rdata(w_rd_x)
  );

  conv_mem #(.WIDTH(WIDTH), .SIZE(LENF), .LOGSIZE(ADDRF)) u_mem_f (
    .clk(clk), .i_we(w_hs_f), .i_re(w_issue), .i_addr(w_addr_f),
    .i_wdata(bus.s_data_in_f), .o_rdata(w_rd_f)
  );

  assign w_xe       = {{WIDTH{w_rd_x[WIDTH-1]}}, w_rd_x};
  assign w_fe       = {{WIDTH{w_rd_f[WIDTH-1]}}, w_rd_f};
  assign w_prod     = w_xe * w_fe;
  assign w_psat     = WIDTH'(saturate(64'(w_prod), WIDTH));
  assign w_sum      = {r_acc[WIDTH-1], r_acc} + {w_psat[WIDTH-1], w_psat};
  assign w_acc_next = WIDTH'(saturate(64'(w_sum), WIDTH));

`ifdef CONV_RELU_EN
  assign w_y_final = (r_acc[WIDTH-1] || (r_acc == '0)) ? '0 : r_acc;
`else
  assign w_y_final = r_acc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_rdy_f = 1'b0;
    w_rdy_x = 1'b0;
    w_vld_y = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (bus.s_valid_f) w_next = S_LOAD_F;
        else if (r_loaded && bus.s_valid_x) w_next = S_LOAD_X;
      end
      S_LOAD_F: begin
        w_rdy_f = 1'b1;
        if (bus.s_valid_f && (r_wa_f == F_LAST)) w_next = S_WAIT;
      end
      S_LOAD_X: begin
        w_rdy_x = 1'b1;
        if (bus.s_valid_x && (r_wa_x == X_LAST)) w_next = S_MAC;
      end
      S_MAC: begin
        if (r_done) w_next = S_OUT;
      end
      S_OUT: begin
        w_vld_y = 1'b1;
        if (bus.m_ready_y) w_next = (r_k == Y_LAST) ? S_WAIT : S_MAC;
      end
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wa_f       <= '0;
      r_wa_x       <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_loaded     <= 1'b0;
      r_issue_done <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_done       <= 1'b0;
      r_acc        <= '0;
      r_y          <= '0;
    end else begin
      case (r_state)
        S_LOAD_F: if (w_hs_f) begin
          if (r_wa_f == F_LAST) begin
            r_wa_f   <= '0;
            r_loaded <= 1'b1;
          end else r_wa_f <= r_wa_f + 1'b1;
        end
        S_LOAD_X: if (w_hs_x) begin
          if (r_wa_x == X_LAST) r_wa_x <= '0;
          else r_wa_x <= r_wa_x + 1'b1;
        end
        S_MAC: begin
          if (!r_issue_done) begin
            r_rd_vld  <= 1'b1;
            r_rd_last <= (r_j == F_LAST);
            if (r_j == F_LAST) r_issue_done <= 1'b1;
            else r_j <= r_j + 1'b1;
          end else begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
          end
          // Data read in the previous cycle is folded in now.
          if (r_rd_vld) begin
            r_acc <= w_acc_next;
            if (r_rd_last) r_done <= 1'b1;
          end
          if (r_done) r_y <= w_y_final;
        end
        S_OUT: if (w_hs_y) begin
          r_j          <= '0;
          r_issue_done <= 1'b0;
          r_done       <= 1'b0;
          r_acc        <= '0;
          if (r_k == Y_LAST) r_k <= '0;
          else r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready_f    = w_rdy_f;
  assign bus.s_ready_x    = w_rdy_x;
  assign bus.m_valid_y    = w_vld_y;
  assign bus.m_data_out_y = r_y;
endmodule

// File: tb/tb_conv_stream_sat.sv
// Scoreboard bench for conv_stream_sat (WIDTH=8, LENX=8, LENF=4) with directed vectors.
// Build with CONV_RELU_EN defined to check the ReLU variant.
module tb_conv_stream_sat;
  localparam int WIDTH = 8;
  localparam int LENX  = 8;
  localparam int LENF  = 4;
  localparam int LENY  = LENX - LENF + 1;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0, cyc = 0, t_hs = 0, nf = 0, nr = 0;
  bit lat_pending = 1'b0, prev_valid = 1'b0;
  int exp_q[$];

  int f_ramp[LENF]  = '{1, 2, 3, 4};
  int f_127[LENF]   = '{127, 127, 127, 127};
  int f_m128[LENF]  = '{-128, -128, -128, -128};
  int f_step[LENF]  = '{127, 127, -128, 0};
  int f_neg1[LENF]  = '{-1, 0, 0, 0};
  int f_ones[LENF]  = '{1, 1, 1, 1};
  int x_ramp[LENX]  = '{1, 2, 3, 4, 5, 6, 7, 8};
  int x_127[LENX]   = '{127, 127, 127, 127, 127, 127, 127, 127};
  int x_five[LENX]  = '{5, 6, 7, 8, 9, 10, 11, 12};
  int y_ramp[LENY]  = '{30, 40, 50, 60, 70};
  int y_127[LENY]   = '{127, 127, 127, 127, 127};
  int y_m128[LENY]  = '{-128, -128, -128, -128, -128};
  int y_step[LENY]  = '{-1, -1, -1, -1, -1};
  int y_five[LENY]  = '{-5, -6, -7, -8, -9};
  int y_ones[LENY]  = '{10, 14, 18, 22, 26};

  conv_stream_sat_if #(.WIDTH(WIDTH)) bus ();

  conv_stream_sat #(.WIDTH(WIDTH), .LENX(LENX), .LENF(LENF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
    return (RELU && v <= 0) ? 0 : v;
  endfunction

  task automatic push_y(input int v[LENY]);
    for (int i = 0; i < LENY; i++) exp_q.push_back(relu(v[i]));
  endtask

  task automatic send_f(input int v[LENF]);
    int n;
    for (int i = 0; i < LENF; i++) begin
      bus.s_data_in_f = WIDTH'(v[i]);
      bus.s_valid_f = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s_ready_f && n < 100);
      if (!bus.s_ready_f) check("send_f_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.s_valid_f = 1'b0;
  endtask

  task automatic send_x(input int v[LENX]);
    int n;
    for (int i = 0; i < LENX; i++) begin
      bus.s_data_in_x = WIDTH'(v[i]);
      bus.s_valid_x = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s_ready_x && n < 100);
      if (!bus.s_ready_x) check("send_x_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.s_valid_x = 1'b0;
    t_hs = cyc;
    lat_pending = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int f[LENF], input int x[LENX], input int y[LENY]);
    push_y(y);
    send_f(f);
    send_x(x);
    drain();
  endtask

  // Manual downstream: ready pulsed per result, result hold_k held for 10 cycles.
  task automatic accept_manual(input int hold_k, input int hold_val);
    int n;
    for (int k = 0; k < LENY; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.m_valid_y && n < 100);
      check("manual_wait_valid", int'(bus.m_valid_y), 1);
      if (k == hold_k) begin
        for (int c = 0; c < 10; c++) begin
          check("hold_valid", int'(bus.m_valid_y), 1);
          check("hold_data", int'(bus.m_data_out_y), hold_val);
          check("hold_ready_x", int'(bus.s_ready_x), 0);
          @(negedge clk);
        end
      end
      @(posedge clk); #1 bus.m_ready_y = 1'b1;
      @(posedge clk); #1 bus.m_ready_y = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (reset) begin
      check("ready_exclusive", int'(bus.s_ready_f & bus.s_ready_x), 0);
      if (bus.m_valid_y && !prev_valid && lat_pending) begin
        check("first_valid_latency", cyc - t_hs, LENF + 2);
        lat_pending = 1'b0;
      end
      if (bus.m_valid_y && bus.m_ready_y) begin
        if (exp_q.size() == 0) check("unexpected_y", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("y_data", int'(bus.m_data_out_y), e);
        end
      end
    end
    prev_valid = bus.m_valid_y;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data_in_f = '0;
    bus.s_valid_f   = 1'b0;
    bus.s_data_in_x = '0;
    bus.s_valid_x   = 1'b0;
    bus.m_ready_y   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_f", int'(bus.s_ready_f), 0);
    check("rst_ready_x", int'(bus.s_ready_x), 0);
    check("rst_valid_y", int'(bus.m_valid_y), 0);
    check("rst_data_y", int'(bus.m_data_out_y), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    run_vec(f_ramp, x_ramp, y_ramp);
    run_vec(f_127, x_127, y_127);
    run_vec(f_m128, x_127, y_m128);
    run_vec(f_step, x_127, y_step);
    run_vec(f_neg1, x_five, y_five);

    bus.m_ready_y = 1'b0;
    push_y(y_ramp);
    send_f(f_ramp);
    send_x(x_ramp);
    accept_manual(2, 50);
    check("hold_drain_left", exp_q.size(), 0);
    bus.m_ready_y = 1'b1;

    push_y(y_ramp);
    send_f(f_ramp);
    send_x(x_ramp);
    nr = 0;
    while (exp_q.size() > LENY - 1 && nr < 100) begin @(negedge clk); nr++; end
    check("reset_wait_y0", exp_q.size(), LENY - 1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    lat_pending = 1'b0;
    @(negedge clk);
    check("midrst_ready_f", int'(bus.s_ready_f), 0);
    check("midrst_ready_x", int'(bus.s_ready_x), 0);
    check("midrst_valid_y", int'(bus.m_valid_y), 0);
    check("midrst_data_y", int'(bus.m_data_out_y), 0);
    @(posedge clk); #1 reset = 1'b1;
    bus.s_data_in_x = WIDTH'(9);
    bus.s_valid_x = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("x_refused_after_reset", int'(bus.s_ready_x), 0);
    end
    @(posedge clk); #1 bus.s_valid_x = 1'b0;
    run_vec(f_ramp, x_ramp, y_ramp);

    push_y(y_ones);
    fork
      send_f(f_ones);
      send_x(x_ramp);
      begin
        nf = 0;
        do begin @(negedge clk); nf++; end
        while (!bus.s_ready_f && !bus.s_ready_x && nf < 50);
        check("filter_wins_ready_f", int'(bus.s_ready_f), 1);
        check("filter_wins_ready_x", int'(bus.s_ready_x), 0);
      end
    join
    drain();
    push_y(y_ones);
    send_x(x_ramp);
    drain();

    repeat (20) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_sat.md
CONV_STREAM_SAT -- requirements
Module: conv_stream_sat

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed sample/coefficient/result width.
REQ-002 SHALL have parameter LENX, default 43: input vector length.
REQ-003 SHALL have parameter LENF, default 16: filter length; legal range 2..LENX.
REQ-004 SHALL derive LENY = LENX-LENF+1, ADDRX = $clog2(LENX), ADDRF = $clog2(LENF) as localparams.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_data_in_f  in  WIDTH  signed filter coefficient stream.
- s_valid_f  in  1  coefficient valid.
- s_ready_f  out  1  coefficient accepted when high with s_valid_f.
- s_data_in_x  in  WIDTH  signed input sample stream.
- s_valid_x  in  1  sample valid.
- s_ready_x  out  1  sample accepted when high with s_valid_x.
- m_data_out_y  out  WIDTH  signed result.
- m_valid_y  out  1  result valid.
- m_ready_y  in  1  downstream accepts result.

Function
REQ-006 SHALL implement FSM states WAIT, LOAD_F, LOAD_X, MAC, OUT.
REQ-007 SHALL sequence the FSM as follows:
- WAIT: s_valid_f -> LOAD_F; else if a filter is loaded and s_valid_x -> LOAD_X.
- Simultaneous s_valid_f and s_valid_x in WAIT: filter wins.
REQ-008 SHALL assert s_ready_f only in LOAD_F, storing coefficients f[0..LENF-1] in arrival order; the LENF-th handshake sets filter_loaded and returns to WAIT.
REQ-009 SHALL assert s_ready_x only in LOAD_X, storing x[0..LENX-1] in arrival order; the LENX-th handshake enters MAC.
REQ-010 SHALL compute y[k] = sum over j=0..LENF-1 of x[k+j]*f[j], for k=0..LENY-1, one product per cycle.
REQ-011 SHALL form each product at full 2*WIDTH signed width, then clamp it to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-012 SHALL add the clamped product to the accumulator at WIDTH+1 bits, then clamp the sum to WIDTH bits on every step (saturate per step, not at the end).
REQ-013 SHALL read both memories synchronously with one-cycle latency; the first m_valid_y SHALL rise exactly LENF+2 cycles after the last x handshake.
REQ-014 SHALL present y[k] in OUT with m_valid_y=1 and m_data_out_y stable until the m_ready_y handshake.
REQ-015 SHALL handle each handshake in OUT as follows:
- k<LENY-1: clear the accumulator and return to MAC for k+1.
- k=LENY-1: return to WAIT.
REQ-016 SHALL keep m_valid_y low outside OUT, and SHALL never raise s_ready_x and s_ready_f in the same cycle.
REQ-017 SHALL retain filter coefficients across vectors until a new LENF-word load completes; a partial reload is completed before leaving LOAD_F.
REQ-018 SHALL use wrap-free counters; address counters SHALL never exceed LENX-1 or LENF-1.

Reset
REQ-019 SHALL, while reset is low, force:
- state=WAIT, all counters 0, accumulator 0, filter_loaded=0.
- s_ready_f=0, s_ready_x=0, m_valid_y=0, m_data_out_y=0.
REQ-020 SHALL, on reset asserted mid-operation, abandon the operation immediately; it SHALL require a fresh filter load, and memory contents are not cleared.

Configuration
REQ-021 SHALL, with CONV_RELU_EN defined, output 0 for any final y[k] <= 0; negative intermediate sums SHALL still accumulate.
REQ-022 SHALL, with CONV_RELU_EN undefined, output signed saturated y[k] unchanged.

Structure
REQ-023 SHALL place the FSM state enum typedef and the saturate function (2*WIDTH -> WIDTH clamp) in shared package conv_pkg.
REQ-024 SHALL instantiate sub-module conv_mem (parametrised WIDTH/SIZE/LOGSIZE single-port synchronous RAM, write-first not required) twice, for x and f.

Verification (WIDTH=8, LENX=8, LENF=4 unless noted)
REQ-025 SHALL load f={1,2,3,4}, x={1..8}, m_ready_y=1 -> y = 30,40,50,60,70, first valid LENF+2 cycles after last x.
REQ-026 SHALL load f={127,127,127,127}, x all 127 -> every y=127; f all -128, x all 127 -> y=-128 (ReLU off) or 0 (ReLU on).
REQ-027 SHALL load f={-1,0,0,0}, x={5,...} -> y[0]=-5 without CONV_RELU_EN, 0 with it.
REQ-028 SHALL hold m_ready_y low 10 cycles on y[2] -> m_valid_y stays 1, data stays 50, s_ready_x stays 0; completion then matches REQ-025.
REQ-029 SHALL pulse reset low during MAC of y[1] -> all outputs 0 next edge; an x offer is refused (s_ready_x=0) until a new filter load.
REQ-030 SHALL assert s_valid_f and s_valid_x together in WAIT -> filter accepted first; a second vector reuses the filter without reload, giving identical y.
